inst_queue: RTL and testbench

Instruction queue between `inst_fetch` and the decode stage. It buffers fetched `{vaddr, inst}` pairs in a small circular FIFO so that icache hit bursts are not lost while decode stalls. It also cuts the combinational ready path from decode back into fetch. On a branch or exception redirect, a single-cycle `flush` discards all buffered entries.

---
 rtl/inst_queue_pkg.sv | 20 ++
 rtl/inst_queue_fifo_ptr.sv | 73 +++++++
 rtl/inst_queue.sv | 102 ++++++++++
 tb/tb_inst_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
//   Shared CPU pipeline types used between fetch, the instruction queue and
//   decode.
//   - pipe_if_t        : one fetched instruction, {vaddr, inst}
//   - INST_QUEUE_DEPTH : buffering between fetch and decode; both sides size
//                        their expectations from this value
// -----------------------------------------------------------------------------
package inst_queue_pkg;

   localparam int PIPE_VADDR_W     = 32;
   localparam int PIPE_INST_W      = 32;
   localparam int INST_QUEUE_DEPTH = 4;

   typedef struct packed {
      logic [PIPE_VADDR_W-1:0] vaddr;
      logic [PIPE_INST_W-1:0]  inst;
   } pipe_if_t;

endpackage

// File: rtl/inst_queue_fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
//   Read/write pointer pair for a circular FIFO of DEPTH entries. Each pointer
//   carries one extra wrap bit, so empty and full are told apart without a
//   separate counter.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset (pointers to 0)
//     clr           : synchronous clear, wins over push/pop
//     push, pop     : completed handshakes this cycle
//     rd_idx        : storage index of the head entry
//     wr_idx        : storage index the next push writes
//     rd_idx_next   : head index after this cycle's update
//     full, empty   : occupancy flags from registered pointers
//     empty_next    : FIFO will be empty after this cycle's update
//     count         : occupancy, wptr - rptr in pointer width
// -----------------------------------------------------------------------------
module fifo_ptr
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = INST_QUEUE_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   output logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic [$clog2(DEPTH)-1:0]   wr_idx,
   output logic [$clog2(DEPTH)-1:0]   rd_idx_next,
   output logic                       full,
   output logic                       empty,
   output logic                       empty_next,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] rptr, wptr;
   logic [PTR_W-1:0] rptr_next, wptr_next;

   always_comb begin
      rptr_next = rptr + PTR_W'(pop);
      wptr_next = wptr + PTR_W'(push);
      if (clr) begin
         rptr_next = '0;
         wptr_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr <= '0;
         wptr <= '0;
      end else begin
         rptr <= rptr_next;
         wptr <= wptr_next;
      end
   end

   assign rd_idx      = rptr[IDX_W-1:0];
   assign wr_idx      = wptr[IDX_W-1:0];
   assign rd_idx_next = rptr_next[IDX_W-1:0];

   // Same slot, different lap: the writer is exactly one lap ahead.
   assign full       = (rptr[IDX_W-1:0] == wptr[IDX_W-1:0]) && (rptr[IDX_W] != wptr[IDX_W]);
   assign empty      = (rptr == wptr);
   assign empty_next = (rptr_next == wptr_next);

   // Modulo 2*DEPTH subtraction gives occupancy 0..DEPTH directly.
   assign count = wptr - rptr;

endmodule

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Instruction queue between fetch and decode. Buffers {vaddr, inst} pairs in
//   a DEPTH-entry circular FIFO so icache hit bursts survive decode stalls,
//   and breaks the ready path from decode back into fetch (in_ready never
//   looks at out_ready). A one-cycle flush discards every buffered entry.
//   Ports:
//     clk, rst                        : clock, synchronous active-high reset
//     flush                           : redirect pulse, empties the queue
//     in_valid/in_ready               : fetch-side handshake
//     in_vaddr, in_inst               : incoming entry
//     out_valid/out_ready             : decode-side handshake
//     out_vaddr, out_inst             : head entry (holds last value when empty)
//     count                           : current occupancy
// -----------------------------------------------------------------------------
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH      = INST_QUEUE_DEPTH,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_WIDTH-1:0]    in_vaddr,
   input  logic [DATA_WIDTH-1:0]    in_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_WIDTH-1:0]    out_vaddr,
   output logic [DATA_WIDTH-1:0]    out_inst,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int IDX_W = $clog2(DEPTH);

   logic             push, pop;
   logic             full, empty, empty_next;
   logic [IDX_W-1:0] rd_idx, wr_idx, rd_idx_next;

   pipe_if_t entry_in;
   pipe_if_t head;
   pipe_if_t mem [DEPTH];

   // Field widths come from the shared package; port widths are cast onto them.
   always_comb begin
      entry_in       = '0;
      entry_in.vaddr = PIPE_VADDR_W'(in_vaddr);
      entry_in.inst  = PIPE_INST_W'(in_inst);
   end

   assign in_ready  = !full && !flush;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   fifo_ptr #(
      .DEPTH (DEPTH)
   ) u_ptr (
      .clk         (clk),
      .rst         (rst),
      .clr         (flush),
      .push        (push),
      .pop         (pop),
      .rd_idx      (rd_idx),
      .wr_idx      (wr_idx),
      .rd_idx_next (rd_idx_next),
      .full        (full),
      .empty       (empty),
      .empty_next  (empty_next),
      .count       (count)
   );

   // Storage is never reset; only slots that have been written are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= entry_in;
      end
   end

   // The head is registered so the outputs are 0 out of reset and hold their
   // last value while empty, instead of showing unwritten storage. When the
   // slot being written this cycle is the next head (queue holds one entry
   // next cycle), the incoming entry is forwarded into the head register.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
      end else if (!empty_next) begin
         if (push && (wr_idx == rd_idx_next)) begin
            head <= entry_in;
         end else begin
            head <= mem[rd_idx_next];
         end
      end
   end

   assign out_vaddr = ADDR_WIDTH'(head.vaddr);
   assign out_inst  = DATA_WIDTH'(head.inst);

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic          in_ready, out_valid;
   logic [AW-1:0] in_vaddr, out_vaddr;
   logic [DW-1:0] in_inst, out_inst;
   logic [CW-1:0] count;

   int errors = 0;
   int checks = 0;

   // Reference model: plain FIFO of {vaddr, inst} plus the last head shown.
   logic [AW+DW-1:0] mq[$];
   logic [AW+DW-1:0] last_out;

   always #5 clk = ~clk;

   inst_queue #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vaddr  (in_vaddr),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_vaddr (out_vaddr),
      .out_inst  (out_inst),
      .count     (count)
   );

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] i,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_vaddr  = a;
      in_inst   = i;
      out_ready = ordy;
      flush     = fl;
      #1;
   endtask

   // Advance one clock and apply the queue rules to the model.
   task automatic tick();
      bit rdy_m, vld_m;
      rdy_m = (mq.size() < DEPTH) && !flush;
      vld_m = (mq.size() != 0);
      if (rst) begin
         mq.delete();
         last_out = '0;
      end else if (flush) begin
         mq.delete();
      end else begin
         if (vld_m && out_ready) void'(mq.pop_front());
         if (in_valid && rdy_m) mq.push_back({in_vaddr, in_inst});
      end
      if (mq.size() != 0) last_out = mq[0];
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, '0, '0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      drive(0, '0, '0, 0, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if ({out_vaddr, out_inst} !== '0) begin errors++; $display("FAIL reset_out_data: got %h_%h want 0", out_vaddr, out_inst); end
   endtask

   task automatic test_fill();
      for (int k = 0; k < 4; k++) begin
         drive(1, 32'hbfc00000 + 32'(4 * k), $urandom, 0, 0);
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", k, in_ready); end
         tick();
      end
      checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_count: got %0d want 4", count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
      drive(1, 32'hbfc00010, $urandom, 0, 0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_5th_ready: got %b want 0", in_ready); end
      tick();
      checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_5th_count: got %0d want 4", count); end
   endtask

   task automatic test_drain();
      for (int k = 0; k < 4; k++) begin
         drive(0, '0, '0, 1, 0);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d: got %b want 1", k, out_valid); end
         checks++; if (out_vaddr !== 32'hbfc00000 + 32'(4 * k)) begin errors++; $display("FAIL drain_vaddr_%0d: got %h want %h", k, out_vaddr, 32'hbfc00000 + 32'(4 * k)); end
         checks++; if (out_inst !== mq[0][DW-1:0]) begin errors++; $display("FAIL drain_inst_%0d: got %h want %h", k, out_inst, mq[0][DW-1:0]); end
         tick();
      end
      drive(0, '0, '0, 0, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b want 0", out_valid); end
      checks++; if (count !== '0) begin errors++; $display("FAIL drain_empty_count: got %0d want 0", count); end
      checks++; if (out_vaddr !== 32'hbfc0000c) begin errors++; $display("FAIL drain_hold_vaddr: got %h want bfc0000c", out_vaddr); end
   endtask

   task automatic test_stream();
      logic [AW-1:0] a [20];
      for (int k = 0; k < 20; k++) a[k] = 32'h80001000 + 32'(4 * k);
      for (int k = 0; k < 20; k++) begin
         drive(1, a[k], $urandom, 1, 0);
         if (k > 0) begin
            checks++; if (out_valid !== 1'b1 || out_vaddr !== a[k-1]) begin errors++; $display("FAIL stream_head_%0d: got %b/%h want 1/%h", k, out_valid, out_vaddr, a[k-1]); end
            checks++; if (count !== CW'(1)) begin errors++; $display("FAIL stream_count_%0d: got %0d want 1", k, count); end
            checks++; if (out_inst !== mq[0][DW-1:0]) begin errors++; $display("FAIL stream_inst_%0d: got %h want %h", k, out_inst, mq[0][DW-1:0]); end
         end
         tick();
      end
      drive(0, '0, '0, 1, 0);
      checks++; if (out_vaddr !== a[19]) begin errors++; $display("FAIL stream_last: got %h want %h", out_vaddr, a[19]); end
      tick();
      drive(0, '0, '0, 0, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 3; k++) begin
         drive(1, 32'hbfc00040 + 32'(4 * k), $urandom, 0, 0);
         tick();
      end
      drive(0, '0, '0, 0, 0);
      checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count); end
      drive(1, 32'hbfc00100, $urandom, 1, 1);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle_ready: got %b want 0", in_ready); end
      tick();
      drive(0, '0, '0, 1, 0);
      checks++; if (count !== '0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: got %b/%h want 0", out_valid, out_vaddr); end
      drive(1, 32'hbfc00200, $urandom, 0, 0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_refetch_ready: got %b want 1", in_ready); end
      tick();
      drive(0, '0, '0, 1, 0);
      checks++; if (out_valid !== 1'b1 || out_vaddr !== 32'hbfc00200) begin errors++; $display("FAIL flush_refetch_head: got %b/%h want 1/bfc00200", out_valid, out_vaddr); end
      tick();
      drive(0, '0, '0, 0, 0);
   endtask

   task automatic test_full_pop();
      for (int k = 0; k < 4; k++) begin
         drive(1, 32'hbfc00300 + 32'(4 * k), $urandom, 0, 0);
         tick();
      end
      drive(1, 32'hbfc00400, $urandom, 1, 0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready: got %b want 0", in_ready); end
      tick();
      drive(0, '0, '0, 0, 0);
      checks++; if (count !== CW'(3)) begin errors++; $display("FAIL fullpop_count: got %0d want 3", count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready_after: got %b want 1", in_ready); end
      for (int k = 1; k < 4; k++) begin
         drive(0, '0, '0, 1, 0);
         checks++; if (out_vaddr !== 32'hbfc00300 + 32'(4 * k)) begin errors++; $display("FAIL fullpop_drain_%0d: got %h want %h", k, out_vaddr, 32'hbfc00300 + 32'(4 * k)); end
         tick();
      end
      drive(0, '0, '0, 0, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_bfc00400_dropped: got %b/%h want 0", out_valid, out_vaddr); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 2; k++) begin
         drive(1, 32'hbfc00500 + 32'(4 * k), $urandom, 0, 0);
         tick();
      end
      drive(0, '0, '0, 0, 0);
      checks++; if (count !== CW'(2)) begin errors++; $display("FAIL rstmid_pre_count: got %0d want 2", count); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(0, '0, '0, 0, 0);
      checks++; if (out_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL rstmid_state: got %b/%0d want 0/0", out_valid, count); end
      checks++; if ({out_vaddr, out_inst} !== '0) begin errors++; $display("FAIL rstmid_data: got %h_%h want 0", out_vaddr, out_inst); end
      drive(1, 32'hbfc00600, 32'h00000013, 0, 0);
      tick();
      drive(1, 32'hbfc00604, 32'h00100093, 0, 0);
      tick();
      drive(0, '0, '0, 1, 0);
      checks++; if (out_vaddr !== 32'hbfc00600 || out_inst !== 32'h00000013) begin errors++; $display("FAIL rstmid_first: got %h/%h want bfc00600/00000013", out_vaddr, out_inst); end
      tick();
      tick();
      drive(0, '0, '0, 0, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
         checks++; if (in_ready !== ((mq.size() < DEPTH) && !flush)) begin errors++; $display("FAIL rand_in_ready_%0d: got %b want %b", n, in_ready, (mq.size() < DEPTH) && !flush); end
         checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rand_out_valid_%0d: got %b want %b", n, out_valid, mq.size() != 0); end
         checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count_%0d: got %0d want %0d", n, count, mq.size()); end
         checks++; if ({out_vaddr, out_inst} !== last_out) begin errors++; $display("FAIL rand_head_%0d: got %h_%h want %h", n, out_vaddr, out_inst, last_out); end
         tick();
      end
      drive(0, '0, '0, 0, 0);
   endtask

   initial begin
      rst      = 1'b1;
      last_out = '0;
      drive(0, '0, '0, 0, 0);
      @(negedge clk);
      test_reset();
      test_fill();
      test_drain();
      test_stream();
      test_flush();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
